// File: rtl/miter_pkg.sv
// Shared types and constants for the miter bus controller.
package miter_pkg;

  // Width of the per-channel latency down-counter (LAT range 1..15).
  localparam int unsigned LAT_W = 4;

  // Bit positions inside div_cause.
  localparam int unsigned CAUSE_IVALID = 0;
  localparam int unsigned CAUSE_IADDR  = 1;
  localparam int unsigned CAUSE_DVALID = 2;
  localparam int unsigned CAUSE_DCTRL  = 3;
  localparam int unsigned CAUSE_W      = 4;

  // Per-channel sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RESP   = 2'd2,
    ST_FROZEN = 2'd3
  } seq_state_t;

endpackage

// File: rtl/miter_chan_seq.sv
// One handshake channel of the miter: accepts a request only when both copies
// present identical control, answers both with a single shared ready pulse
// after LAT cycles, and flags any control divergence between the copies.
module miter_chan_seq
  import miter_pkg::*;
#(
  parameter int unsigned LAT   = 1,
  parameter int unsigned CMP_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             valid1,
  input  logic             valid2,
  input  logic [CMP_W-1:0] ctrl1,
  input  logic [CMP_W-1:0] ctrl2,
  output logic             ready,
  output logic             valid_mis,
  output logic             ctrl_mis
);

  seq_state_t       state, state_nxt;
  logic [LAT_W-1:0] cnt, cnt_nxt;
  logic [CMP_W-1:0] held;
  logic             accept;

  // Mismatch detection; nothing is reported once the channel is frozen.
  always_comb begin
    valid_mis = 1'b0;
    ctrl_mis  = 1'b0;
    case (state)
      ST_IDLE: begin
        valid_mis = valid1 ^ valid2;
        ctrl_mis  = valid1 & valid2 & (ctrl1 != ctrl2);
      end
      ST_WAIT, ST_RESP: begin
        // Both requests must stay up until ready; a side that dropped is
        // already reported as a valid mismatch, so only live sides are
        // compared against the accepted control word.
        valid_mis = ~(valid1 & valid2);
        ctrl_mis  = (valid1 & (ctrl1 != held)) | (valid2 & (ctrl2 != held));
      end
      default: begin
        valid_mis = 1'b0;
        ctrl_mis  = 1'b0;
      end
    endcase
  end

  assign accept = (state == ST_IDLE) & valid1 & valid2 & (ctrl1 == ctrl2);

  // Next-state and latency counter; a freeze overrides any pending RESP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_nxt   = LAT_W'(LAT - 1);
          state_nxt = (LAT == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - LAT_W'(1);
        if (cnt == LAT_W'(1)) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_FROZEN;
    endcase
    if (freeze) begin
      state_nxt = ST_FROZEN;
    end
  end

  // State, counter, accepted control word and registered ready pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      held  <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        held <= ctrl1;
      end
      ready <= (state_nxt == ST_RESP);
    end
  end

endmodule

// File: rtl/miter_bus_ctrl.sv
// Handshake sequencer and timing-divergence monitor for the two-copy miter.
// Both cores see ready from one shared model per bus; the first control
// divergence is captured with its cause and cycle stamp and freezes both buses.
module miter_bus_ctrl
  import miter_pkg::*;
#(
  parameter int unsigned ILAT  = 1,
  parameter int unsigned DLAT  = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ivalid1,
  input  logic             ivalid2,
  input  logic [31:0]      iaddr1,
  input  logic [31:0]      iaddr2,
  output logic             iready1,
  output logic             iready2,
  input  logic             dvalid1,
  input  logic             dvalid2,
  input  logic [31:0]      daddr1,
  input  logic [31:0]      daddr2,
  input  logic             dwrite1,
  input  logic             dwrite2,
  input  logic [3:0]       dwstb1,
  input  logic [3:0]       dwstb2,
  output logic             dready1,
  output logic             dready2,
  output logic             diverge,
  output logic [3:0]       div_cause,
  output logic [CNT_W-1:0] div_cycle,
  output logic [CNT_W-1:0] cycle
);

  logic               i_ready, i_vmis, i_cmis;
  logic               d_ready, d_vmis, d_cmis;
  logic [CAUSE_W-1:0] cause_now;
  logic               freeze;

  miter_chan_seq #(
    .LAT   (ILAT),
    .CMP_W (32)
  ) u_iseq (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .valid1    (ivalid1),
    .valid2    (ivalid2),
    .ctrl1     (iaddr1),
    .ctrl2     (iaddr2),
    .ready     (i_ready),
    .valid_mis (i_vmis),
    .ctrl_mis  (i_cmis)
  );

  miter_chan_seq #(
    .LAT   (DLAT),
    .CMP_W (37)
  ) u_dseq (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .valid1    (dvalid1),
    .valid2    (dvalid2),
    .ctrl1     ({daddr1, dwrite1, dwstb1}),
    .ctrl2     ({daddr2, dwrite2, dwstb2}),
    .ready     (d_ready),
    .valid_mis (d_vmis),
    .ctrl_mis  (d_cmis)
  );

  assign iready1 = i_ready;
  assign iready2 = i_ready;
  assign dready1 = d_ready;
  assign dready2 = d_ready;

  // Gather this cycle's mismatch causes from both channels.
  always_comb begin
    cause_now               = '0;
    cause_now[CAUSE_IVALID] = i_vmis;
    cause_now[CAUSE_IADDR]  = i_cmis;
    cause_now[CAUSE_DVALID] = d_vmis;
    cause_now[CAUSE_DCTRL]  = d_cmis;
  end

  // Only the first divergence freezes; afterwards both channels sit in FROZEN.
  assign freeze = ~diverge & (|cause_now);

  // Free-running cycle counter and sticky first-divergence capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle     <= '0;
      diverge   <= 1'b0;
      div_cause <= '0;
      div_cycle <= '0;
    end else begin
      cycle <= cycle + CNT_W'(1);
      if (freeze) begin
        diverge   <= 1'b1;
        div_cause <= cause_now;
        div_cycle <= cycle;
      end
    end
  end

endmodule
